// File: rtl/jtlabrun_rom_arb_pkg.sv
// ============================================================================
// jtlabrun_rom_arb_pkg : shared encodings and default SDRAM offsets for the
//                        Labyrinth Runner ROM arbiter.
// Rev 1.0
// ============================================================================
`default_nettype none

package jtlabrun_rom_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      CL_CPU = 2'd0,
      CL_GFX = 2'd1,
      CL_OBJ = 2'd2
   } client_t;

   localparam logic [21:0] DEF_CPU_OFFSET = 22'h00000;
   localparam logic [21:0] DEF_GFX_OFFSET = 22'h10000;
   localparam logic [21:0] DEF_OBJ_OFFSET = 22'h90000;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

`default_nettype wire

// File: rtl/jtlabrun_rom_slot.sv
// ============================================================================
// jtlabrun_rom_slot : one-entry ROM cache (tag/valid/data) with hit compare
//                     and an arbiter-driven write port.
// Rev 1.0
// ============================================================================
`default_nettype none

module jtlabrun_rom_slot #(
   parameter int AW = 18,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cs,
   input  logic [AW-1:0] addr,
   output logic [DW-1:0] data,
   output logic          ok,
   input  logic          we,
   input  logic [AW-1:0] wr_tag,
   input  logic [DW-1:0] wr_data
);

   logic          valid;
   logic [AW-1:0] tag;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         tag   <= '0;
         data  <= '0;
      end else if (we) begin
         valid <= 1'b1;
         tag   <= wr_tag;
         data  <= wr_data;
      end
   end

   assign ok = cs & valid & (addr == tag);

endmodule

`default_nettype wire

// File: rtl/jtlabrun_rom_arb.sv
// ============================================================================
// jtlabrun_rom_arb : shares one SDRAM read port between CPU, tile and object
//                    ROM caches; CPU has priority, GFX/OBJ alternate.
// Rev 1.0
// ============================================================================
`default_nettype none

module jtlabrun_rom_arb
   import jtlabrun_rom_arb_pkg::*;
#(
   parameter int                  CPU_AW     = 17,
   parameter int                  GFX_AW     = 18,
   parameter int                  OBJ_AW     = 18,
   parameter int                  SDRAM_AW   = 22,
   parameter logic [SDRAM_AW-1:0] CPU_OFFSET = SDRAM_AW'(DEF_CPU_OFFSET),
   parameter logic [SDRAM_AW-1:0] GFX_OFFSET = SDRAM_AW'(DEF_GFX_OFFSET),
   parameter logic [SDRAM_AW-1:0] OBJ_OFFSET = SDRAM_AW'(DEF_OBJ_OFFSET)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cpu_cs,
   input  logic [CPU_AW-1:0]   cpu_addr,
   output logic [7:0]          cpu_data,
   output logic                cpu_ok,
   input  logic                gfx_cs,
   input  logic [GFX_AW-1:0]   gfx_addr,
   output logic [31:0]         gfx_data,
   output logic                gfx_ok,
   input  logic                obj_cs,
   input  logic [OBJ_AW-1:0]   obj_addr,
   output logic [31:0]         obj_data,
   output logic                obj_ok,
   output logic                sdram_req,
   output logic [SDRAM_AW-1:0] sdram_addr,
   input  logic                sdram_ack,
   input  logic                data_rdy,
   input  logic [31:0]         data_read
);

   localparam int CPU_TW = CPU_AW - 1;
   localparam int TW     = max3(CPU_TW, GFX_AW, OBJ_AW);

   state_t              state, state_nxt;
   client_t             client, client_nxt;
   logic                rr_obj, rr_obj_nxt;
   logic [TW-1:0]       tag, tag_nxt;
   logic [SDRAM_AW-1:0] addr_nxt;
   logic [SDRAM_AW-1:0] cpu_sdram, gfx_sdram, obj_sdram;
   logic                cpu_miss, gfx_miss, obj_miss;
   logic                cpu_we, gfx_we, obj_we;
   logic [15:0]         cpu_word;

   // Only the addressed 16-bit word can ever hit, so the CPU slot keeps just
   // the low half of each SDRAM read.
   jtlabrun_rom_slot #(.AW(CPU_TW), .DW(16)) u_cpu_slot (
      .clk     (clk),
      .rst     (rst),
      .cs      (cpu_cs),
      .addr    (cpu_addr[CPU_AW-1:1]),
      .data    (cpu_word),
      .ok      (cpu_ok),
      .we      (cpu_we),
      .wr_tag  (tag[CPU_TW-1:0]),
      .wr_data (data_read[15:0])
   );

   jtlabrun_rom_slot #(.AW(GFX_AW), .DW(32)) u_gfx_slot (
      .clk     (clk),
      .rst     (rst),
      .cs      (gfx_cs),
      .addr    (gfx_addr),
      .data    (gfx_data),
      .ok      (gfx_ok),
      .we      (gfx_we),
      .wr_tag  (tag[GFX_AW-1:0]),
      .wr_data (data_read)
   );

   jtlabrun_rom_slot #(.AW(OBJ_AW), .DW(32)) u_obj_slot (
      .clk     (clk),
      .rst     (rst),
      .cs      (obj_cs),
      .addr    (obj_addr),
      .data    (obj_data),
      .ok      (obj_ok),
      .we      (obj_we),
      .wr_tag  (tag[OBJ_AW-1:0]),
      .wr_data (data_read)
   );

   assign cpu_data  = cpu_addr[0] ? cpu_word[15:8] : cpu_word[7:0];
   assign cpu_miss  = cpu_cs & ~cpu_ok;
   assign gfx_miss  = gfx_cs & ~gfx_ok;
   assign obj_miss  = obj_cs & ~obj_ok;
   assign cpu_sdram = CPU_OFFSET + SDRAM_AW'(cpu_addr[CPU_AW-1:1]);
   assign gfx_sdram = GFX_OFFSET + SDRAM_AW'({gfx_addr, 1'b0});
   assign obj_sdram = OBJ_OFFSET + SDRAM_AW'({obj_addr, 1'b0});
   assign sdram_req = (state == ST_REQ);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         client     <= CL_CPU;
         rr_obj     <= 1'b0;
         tag        <= '0;
         sdram_addr <= '0;
      end else begin
         state      <= state_nxt;
         client     <= client_nxt;
         rr_obj     <= rr_obj_nxt;
         tag        <= tag_nxt;
         sdram_addr <= addr_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      client_nxt = client;
      rr_obj_nxt = rr_obj;
      tag_nxt    = tag;
      addr_nxt   = sdram_addr;
      cpu_we     = 1'b0;
      gfx_we     = 1'b0;
      obj_we     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cpu_miss) begin
               client_nxt = CL_CPU;
               tag_nxt    = TW'(cpu_addr[CPU_AW-1:1]);
               addr_nxt   = cpu_sdram;
               state_nxt  = ST_REQ;
            end else if (gfx_miss && (!obj_miss || !rr_obj)) begin
               client_nxt = CL_GFX;
               tag_nxt    = TW'(gfx_addr);
               addr_nxt   = gfx_sdram;
               rr_obj_nxt = 1'b1;
               state_nxt  = ST_REQ;
            end else if (obj_miss) begin
               client_nxt = CL_OBJ;
               tag_nxt    = TW'(obj_addr);
               addr_nxt   = obj_sdram;
               rr_obj_nxt = 1'b0;
               state_nxt  = ST_REQ;
            end
         end
         ST_REQ: begin
            if (sdram_ack) state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (data_rdy) begin
               cpu_we    = (client == CL_CPU);
               gfx_we    = (client == CL_GFX);
               obj_we    = (client == CL_OBJ);
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

`default_nettype wire

// File: doc/jtlabrun_rom_arb.md
Name: jtlabrun_rom_arb

Overview:
- Shares the single SDRAM read port between three ROM requesters of the Labyrinth Runner core: main 6809 program ROM (byte, banked 17-bit address), tile ROM (32-bit) and object ROM (32-bit).
- Each requester has a one-entry cache with an address/valid tag and a cs/ok handshake. A miss queues an SDRAM read; a fixed-priority plus round-robin scheduler sequences the reads.
- Sits between the main CPU/GFX blocks and the SDRAM controller.

Parameters:
- CPU_AW, 17: CPU ROM byte-address width.
- GFX_AW, 18: tile ROM 32-bit-word address width.
- OBJ_AW, 18: object ROM 32-bit-word address width.
- SDRAM_AW, 22: SDRAM 16-bit-word address width.
- CPU_OFFSET, 22'h00000: SDRAM base of CPU ROM.
- GFX_OFFSET, 22'h10000: SDRAM base of tile ROM.
- OBJ_OFFSET, 22'h90000: SDRAM base of object ROM.

Ports:
- clk  in  1  system clock, 48 MHz
- rst  in  1  synchronous, active-high reset
- cpu_cs  in  1  CPU ROM read request
- cpu_addr  in  CPU_AW  CPU byte address
- cpu_data  out  8  CPU ROM byte
- cpu_ok  out  1  cpu_data valid for current cpu_addr
- gfx_cs  in  1  tile ROM request
- gfx_addr  in  GFX_AW  tile 32-bit-word address
- gfx_data  out  32  tile data
- gfx_ok  out  1  gfx_data valid
- obj_cs  in  1  object ROM request
- obj_addr  in  OBJ_AW  object 32-bit-word address
- obj_data  out  32  object data
- obj_ok  out  1  obj_data valid
- sdram_req  out  1  read request, held until ack
- sdram_addr  out  SDRAM_AW  16-bit-word address
- sdram_ack  in  1  one-cycle pulse: request accepted
- data_rdy  in  1  one-cycle pulse: data_read valid
- data_read  in  32  SDRAM data; low half = word at sdram_addr

Behaviour:
- Reset: clk rising edge with rst=1.
  - All valids cleared; state IDLE.
  - sdram_req=0, sdram_addr=0.
  - All *_ok=0; all *_data=0; rr pointer=GFX.
- Tags:
  - CPU tag = cpu_addr[CPU_AW-1:1]; the cached 32-bit word covers bytes addr..addr+3. Restrict hit to the same 16-bit word.
  - cpu_data = cached bits [7:0] if cpu_addr[0]=0, else [15:8].
  - GFX/OBJ tag = full address.
- Hit/miss:
  - ok = cs & valid & (addr==tag). Combinational from registered tag, no added latency.
  - Miss = cs & ~ok.
- SDRAM address mapping:
  - CPU: OFFSET + cpu_addr[CPU_AW-1:1].
  - GFX/OBJ: OFFSET + {addr,1'b0}.
  - Sums truncated to SDRAM_AW; wrap-around allowed.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: if any miss, grant, latch client id and address, set sdram_req, go to REQ.
    - Priority: CPU first. Otherwise GFX/OBJ round-robin; after a GFX/OBJ grant, the pointer moves to the other client.
  - REQ: sdram_req held. On sdram_ack: drop sdram_req, go to WAIT. Requests are not withdrawn.
  - WAIT: on data_rdy, write data_read, latched tag and valid=1 into the granted slot; go to IDLE.
- Latency: miss seen in cycle N gives sdram_req in N+1. data_rdy in cycle K makes ok visible in K+1 (if the address is unchanged).
- data_rdy in IDLE/REQ is ignored. sdram_ack in IDLE/WAIT is ignored.
- Address change mid-flight: the slot still stores data under the latched tag; ok stays low for the new address; the new miss is served next.
- cs dropped mid-flight: the transaction completes and is stored.
- Reset mid-transaction: abandon it, state IDLE, sdram_req=0. A later data_rdy is ignored.
- Back-to-back service: IDLE→REQ costs one cycle, so at most one grant per transaction. There is no pipelining.
- Starvation: CPU misses occur at most about once per 3 MHz cycle, so GFX/OBJ progress is guaranteed.

Decomposition:
- Shared header jtlabrun_rom.vh: state encodings (IDLE=2'd0, REQ=2'd1, WAIT=2'd2), client ids (CPU=0, GFX=1, OBJ=2), default offsets.
- Sub-module jtlabrun_rom_slot (params AW, DW): tag/valid/data registers, hit compare, and write port from the arbiter. Instantiated three times.
- The arbiter FSM stays in the top module.

Test Plan:
- Reset then cpu_cs=1, cpu_addr=17'h08001 → sdram_req next cycle with sdram_addr=22'h04000. On data_rdy with data_read=32'h1234ABCD, cpu_ok=1 next cycle and cpu_data=8'hAB. Then cpu_addr=17'h08000 → cpu_data=8'hCD immediately, no new sdram_req.
- CPU, GFX and OBJ misses in the same cycle → grant order CPU, GFX, OBJ. Repeat GFX/OBJ misses → OBJ and GFX alternate.
- gfx_addr=18'h00010 → sdram_addr=22'h10020. Change gfx_addr to 18'h00011 during WAIT → gfx_ok stays 0 and a second request is issued for 22'h10022.
- obj_cs dropped during REQ → transaction completes. Re-asserting the same address gives obj_ok=1 with no new request.
- rst asserted during WAIT → sdram_req=0 and all ok=0. A stray data_rdy afterwards leaves all valids 0.
- Spurious data_rdy/sdram_ack in IDLE → no state change and no slot update.
